dbus_router: RTL and testbench
==============================

Name: dbus_router

Overview:
- Parametrised data-bus router between the CPU data port and its targets: one byte-enabled BRAM port plus NUM_IO peripheral channels.
- Successor to the fixed one-bit mem/IO split with single-cycle load tracking. Adds:
  - configurable BRAM read latency
  - N decoded IO channels with per-channel ready handshake
  - IO timeout with bus-error reporting
- Sits between cpu data port and bram/periph instances in soc.

Parameters:
- AW, 16, CPU data address width
- MEM_AW, 9, BRAM word-address width; uses i_addr[MEM_AW:1]
- MEM_RD_LAT, 1, BRAM read latency in cycles, legal 1..4
- NUM_IO, 4, IO channel count, power of two, 1..8
- IO_SEL_LSB, 12, LSB of the IO channel index field in i_addr
- IO_TMO, 255, max cycles to wait for i_io_rdy before error, 1..1023

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_insn_ce  in  1  CPU instruction advance; ends current access
- i_addr  in  AW  CPU data address; bit AW-1 = 1 selects IO
- i_sw / i_sb / i_lw / i_lb  in  1 each  CPU access strobes, held until i_insn_ce
- i_wdata  in  16  CPU store data
- o_rdata  out  16  load data to CPU
- o_rdy  out  1  access complete
- o_bus_err  out  1  one-cycle pulse on IO timeout
- o_mem_en  out  1  BRAM port enable
- o_mem_addr  out  MEM_AW  BRAM word address
- o_mem_we_h / o_mem_we_l  out  1 each  BRAM byte write enables
- o_mem_din_h / o_mem_din_l  out  8 each  BRAM write bytes
- i_mem_dout_h / i_mem_dout_l  in  8 each  BRAM read bytes
- o_io_sel  out  NUM_IO  one-hot channel select
- o_io_we / o_io_re  out  1 each  IO write / read strobe
- o_io_addr  out  AW  address forwarded to IO
- o_io_wdata  out  16  IO write data
- i_io_rdata  in  NUM_IO*16  per-channel read data, channel k at [16k+15:16k]
- i_io_rdy  in  NUM_IO  per-channel ready

Behaviour:
- Decode:
  - acc = sw|sb|lw|lb
  - io = i_addr[AW-1]
  - ch = i_addr[IO_SEL_LSB +: log2(NUM_IO)]
  - lane = i_addr[1]; lane 1 is the low byte, lane 0 is the high byte
- Stores:
  - sw writes both bytes.
  - sb writes i_wdata[7:0] to the lane byte only (we_l if lane 1, we_h if lane 0); din_h = sw ? wdata[15:8] : wdata[7:0].
  - Write enables are gated by ~io.
  - Memory store: o_rdy = 1 combinationally, same cycle.
- FSM states: IDLE, MEM_RD, IO_WAIT, DONE.
- Transitions:
  - IDLE + mem load -> MEM_RD; lat_cnt = 0.
  - MEM_RD: lat_cnt increments each cycle; when lat_cnt == MEM_RD_LAT-1, capture steered data -> DONE.
  - IDLE + io access -> IO_WAIT; tmo_cnt = 0.
  - IO_WAIT: if i_io_rdy[ch] = 1, capture i_io_rdata[ch] (reads only) -> DONE. Else if tmo_cnt == IO_TMO, data = 16'h0000, pulse o_bus_err -> DONE. Else tmo_cnt++.
  - DONE: o_rdy = 1, o_rdata = captured value, held until i_insn_ce -> IDLE.
  - i_insn_ce in any state forces IDLE on the next cycle; an access in flight is abandoned with no err pulse.
- Load data:
  - lw = {dout_h, dout_l}.
  - lb = zero-extended lane byte.
- o_rdy is 0 in IDLE for loads and IO accesses, and 0 in MEM_RD/IO_WAIT. Idle with no access: o_rdy = 1.
- o_io_sel / o_io_we / o_io_re are asserted only in IO_WAIT, and stay asserted through the ready cycle.
- o_mem_en = acc & ~io (all states). o_mem_addr = i_addr[MEM_AW:1].
- Simultaneous i_io_rdy and timeout: ready wins, no error.
- Reset: FSM IDLE, counters 0, captured data 0, o_bus_err 0. o_io_sel / o_io_we / o_io_re are 0 on the first cycle after reset.
- Access strobes changing mid-access without i_insn_ce are unsupported.

Optional Feature:
- Macro: DBUS_ERR_CAPTURE_EN.
- Defined:
  - Adds outputs o_err_addr[AW] and o_err_valid.
  - On a timeout, o_err_valid is set sticky and o_err_addr latches i_addr.
  - Only i_rst clears them.
  - A later timeout overwrites o_err_addr.
- Undefined: no ports, no registers.

Decomposition:
- Package dbus_pkg holds:
  - FSM state encodings
  - IO_ERR_DATA = 16'h0000
  - IO region bit index function AW-1
  - a clog2 helper for channel index width
- Sub-module dbus_lane_steer: combinational byte-lane write steering and load extract. It is the only natural split; the FSM and counters stay in dbus_router.

Test Plan:
- sw 16'hA55A to 16'h0010, then lw 16'h0010 with MEM_RD_LAT=2 -> o_rdy low 2 cycles after issue, then o_rdata = 16'hA55A until i_insn_ce.
- sb 16'h0077 to 16'h0012 (lane 1) over stored 16'h1234 -> we_l only; lb of 16'h0012 returns 16'h0077; lb of 16'h0010 returns 16'h0012.
- lw 16'h8000 | (2<<12) with ch2 rdy after 5 cycles and rdata 16'hBEEF -> o_io_sel = 4'b0100, o_rdy on the cycle after rdy, o_rdata = 16'hBEEF, no err.
- IO read to ch1 with rdy never asserted, IO_TMO = 8 -> o_bus_err single pulse after 9 wait cycles, o_rdata = 16'h0000, o_rdy = 1. With DBUS_ERR_CAPTURE_EN: o_err_addr = 16'h9000, o_err_valid = 1.
- i_rst asserted during IO_WAIT -> next cycle o_io_sel = 0, o_io_re = 0, FSM IDLE, no err pulse.
- i_io_rdy and timeout in the same cycle -> data captured, o_bus_err stays 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared state encoding, constants and elaboration helpers for
// the data-bus router and its lane steering logic.
package dbus_pkg;

    // Router FSM states, also exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM_RD  = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } dbus_state_t;

    // Load data returned when an IO channel never answers.
    localparam logic [15:0] IO_ERR_DATA = 16'h0000;

    // The top address bit selects the IO region.
    function automatic int io_region_bit(input int aw);
        return aw - 1;
    endfunction

    // Channel index width; a single channel still gets a one-bit index so
    // no zero-width vectors appear.
    function automatic int ch_idx_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dbus_lane_steer.sv
// dbus_lane_steer: combinational byte-lane steering between the CPU data
// port and a 16-bit BRAM port split into high and low bytes.
// Address lane 1 maps to the low byte, lane 0 to the high byte.
module dbus_lane_steer
(
    input  logic        i_sw,
    input  logic        i_sb,
    input  logic        i_lw,
    input  logic        i_io,
    input  logic        i_lane,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_dout_h,
    input  logic [7:0]  i_dout_l,
    output logic        o_we_h,
    output logic        o_we_l,
    output logic [7:0]  o_din_h,
    output logic [7:0]  o_din_l,
    output logic [15:0] o_load_data
);

    // Byte write enables and data: a byte store replicates the low data
    // byte onto both lanes and enables only the addressed one.
    always_comb begin
        o_we_h      = ~i_io & (i_sw | (i_sb & ~i_lane));
        o_we_l      = ~i_io & (i_sw | (i_sb & i_lane));
        o_din_h     = i_sw ? i_wdata[15:8] : i_wdata[7:0];
        o_din_l     = i_wdata[7:0];
        o_load_data = i_lw ? {i_dout_h, i_dout_l}
                           : {8'h00, (i_lane ? i_dout_l : i_dout_h)};
    end

endmodule

// File: rtl/dbus_router.sv
// dbus_router: routes CPU data accesses to a byte-enabled BRAM port with a
// configurable read latency, or to one of NUM_IO decoded IO channels with
// a per-channel ready and a timeout that reports a bus error.
//
// Optional build macro DBUS_ERR_CAPTURE_EN adds o_err_addr / o_err_valid,
// a sticky record of the address of the most recent IO timeout.
//
// Handshake: the CPU raises one access strobe (sw/sb/lw/lb) with a stable
// address and holds it until it pulses i_insn_ce. o_rdy high means the
// access is complete and, for loads, that o_rdata is valid; o_rdy and
// o_rdata then stay put until i_insn_ce, which returns the router to idle
// on the next cycle whatever state it is in. IO channels are addressed by
// o_io_sel with o_io_we/o_io_re held until the selected i_io_rdy bit is
// seen high for one cycle; that cycle completes the channel transfer.
module dbus_router
    import dbus_pkg::*;
#(
    parameter int AW         = 16,
    parameter int MEM_AW     = 9,
    parameter int MEM_RD_LAT = 1,
    parameter int NUM_IO     = 4,
    parameter int IO_SEL_LSB = 12,
    parameter int IO_TMO     = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_insn_ce,
    input  logic [AW-1:0]        i_addr,
    input  logic                 i_sw,
    input  logic                 i_sb,
    input  logic                 i_lw,
    input  logic                 i_lb,
    input  logic [15:0]          i_wdata,
    output logic [15:0]          o_rdata,
    output logic                 o_rdy,
    output logic                 o_bus_err,
    output logic                 o_mem_en,
    output logic [MEM_AW-1:0]    o_mem_addr,
    output logic                 o_mem_we_h,
    output logic                 o_mem_we_l,
    output logic [7:0]           o_mem_din_h,
    output logic [7:0]           o_mem_din_l,
    input  logic [7:0]           i_mem_dout_h,
    input  logic [7:0]           i_mem_dout_l,
    output logic [NUM_IO-1:0]    o_io_sel,
    output logic                 o_io_we,
    output logic                 o_io_re,
    output logic [AW-1:0]        o_io_addr,
    output logic [15:0]          o_io_wdata,
    input  logic [NUM_IO*16-1:0] i_io_rdata,
    input  logic [NUM_IO-1:0]    i_io_rdy,
    output dbus_state_t          o_dbg_state
`ifdef DBUS_ERR_CAPTURE_EN
    ,
    output logic [AW-1:0]        o_err_addr,
    output logic                 o_err_valid
`endif
);

    localparam int         IO_BIT   = io_region_bit(AW);
    localparam int         CH_W     = ch_idx_w(NUM_IO);
    localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);
    localparam logic [9:0] TMO_LAST = 10'(IO_TMO);

    // Access decode
    logic            is_store;
    logic            is_load;
    logic            acc;
    logic            is_io;
    logic            lane;
    logic [CH_W-1:0] ch;
    logic            ch_rdy;
    logic [15:0]     ch_rdata;
    logic [15:0]     steer_data;

    // FSM and datapath registers with their next values
    dbus_state_t state;
    dbus_state_t state_nxt;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_nxt;
    logic [9:0]  tmo_cnt;
    logic [9:0]  tmo_nxt;
    logic [15:0] cap_data;
    logic [15:0] cap_nxt;
    logic        bus_err;
    logic        bus_err_nxt;
    logic        io_active;

`ifdef DBUS_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr;
    logic          err_valid;
`endif

    assign is_store = i_sw | i_sb;
    assign is_load  = i_lw | i_lb;
    assign acc      = is_store | is_load;
    assign is_io    = i_addr[IO_BIT];
    assign lane     = i_addr[1];

    // Channel index, ready and read data for the addressed channel.
    generate
        if (NUM_IO > 1) begin : g_multi_ch
            assign ch       = i_addr[IO_SEL_LSB +: CH_W];
            assign ch_rdy   = i_io_rdy[ch];
            assign ch_rdata = i_io_rdata[16*int'(ch) +: 16];
        end else begin : g_single_ch
            assign ch       = '0;
            assign ch_rdy   = i_io_rdy[0];
            assign ch_rdata = i_io_rdata[15:0];
        end
    endgenerate

    dbus_lane_steer u_lane_steer (
        .i_sw        (i_sw),
        .i_sb        (i_sb),
        .i_lw        (i_lw),
        .i_io        (is_io),
        .i_lane      (lane),
        .i_wdata     (i_wdata),
        .i_dout_h    (i_mem_dout_h),
        .i_dout_l    (i_mem_dout_l),
        .o_we_h      (o_mem_we_h),
        .o_we_l      (o_mem_we_l),
        .o_din_h     (o_mem_din_h),
        .o_din_l     (o_mem_din_l),
        .o_load_data (steer_data)
    );

    assign o_mem_en   = acc & ~is_io;
    assign o_mem_addr = i_addr[MEM_AW:1];
    assign o_io_addr  = i_addr;
    assign o_io_wdata = i_wdata;

    // State, counter and captured-data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            tmo_cnt  <= '0;
            cap_data <= '0;
            bus_err  <= 1'b0;
`ifdef DBUS_ERR_CAPTURE_EN
            err_addr  <= '0;
            err_valid <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            tmo_cnt  <= tmo_nxt;
            cap_data <= cap_nxt;
            bus_err  <= bus_err_nxt;
`ifdef DBUS_ERR_CAPTURE_EN
            if (bus_err_nxt) begin
                err_valid <= 1'b1;
                err_addr  <= i_addr;
            end
`endif
        end
    end

    // Next-state, counters, capture and completion logic.
    always_comb begin
        state_nxt   = state;
        lat_nxt     = lat_cnt;
        tmo_nxt     = tmo_cnt;
        cap_nxt     = cap_data;
        bus_err_nxt = 1'b0;
        io_active   = 1'b0;
        o_rdy       = 1'b0;

        case (state)
            ST_IDLE: begin
                // Memory stores finish in the issue cycle.
                o_rdy = ~acc | (~is_io & is_store);
                if (acc & is_io) begin
                    state_nxt = ST_IO_WAIT;
                    tmo_nxt   = '0;
                end else if (acc & is_load) begin
                    state_nxt = ST_MEM_RD;
                    lat_nxt   = '0;
                end
            end
            ST_MEM_RD: begin
                if (lat_cnt == LAT_LAST) begin
                    cap_nxt   = steer_data;
                    state_nxt = ST_DONE;
                end else begin
                    lat_nxt = lat_cnt + 3'd1;
                end
            end
            ST_IO_WAIT: begin
                io_active = 1'b1;
                // Ready takes priority over a timeout in the same cycle.
                if (ch_rdy) begin
                    if (is_load) cap_nxt = ch_rdata;
                    state_nxt = ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    cap_nxt     = IO_ERR_DATA;
                    bus_err_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    tmo_nxt = tmo_cnt + 10'd1;
                end
            end
            ST_DONE: begin
                o_rdy = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Instruction advance abandons whatever is in flight, silently.
        if (i_insn_ce) begin
            state_nxt   = ST_IDLE;
            bus_err_nxt = 1'b0;
        end
    end

    // IO strobes are driven only while waiting on a channel.
    always_comb begin
        o_io_sel = io_active ? (NUM_IO'(1) << ch) : '0;
        o_io_we  = io_active & is_store;
        o_io_re  = io_active & is_load;
    end

    assign o_rdata     = cap_data;
    assign o_bus_err   = bus_err;
    assign o_dbg_state = state;

`ifdef DBUS_ERR_CAPTURE_EN
    assign o_err_addr  = err_addr;
    assign o_err_valid = err_valid;
`endif

endmodule

// File: tb/tb_dbus_router.sv
// tb_dbus_router: directed bench for dbus_router with MEM_RD_LAT=2 and
// IO_TMO=8. A cycle-age model of the access rules predicts every output on
// every cycle; literal expectations pin latencies and returned data.
`timescale 1ns/1ps
module tb_dbus_router;
    import dbus_pkg::*;

    localparam int AW         = 16;
    localparam int MEM_AW     = 9;
    localparam int MEM_RD_LAT = 2;
    localparam int NUM_IO     = 4;
    localparam int IO_SEL_LSB = 12;
    localparam int IO_TMO     = 8;

    logic                 i_clk;
    logic                 i_rst;
    logic                 i_insn_ce;
    logic [AW-1:0]        i_addr;
    logic                 i_sw, i_sb, i_lw, i_lb;
    logic [15:0]          i_wdata;
    logic [15:0]          o_rdata;
    logic                 o_rdy;
    logic                 o_bus_err;
    logic                 o_mem_en;
    logic [MEM_AW-1:0]    o_mem_addr;
    logic                 o_mem_we_h, o_mem_we_l;
    logic [7:0]           o_mem_din_h, o_mem_din_l;
    logic [7:0]           i_mem_dout_h, i_mem_dout_l;
    logic [NUM_IO-1:0]    o_io_sel;
    logic                 o_io_we, o_io_re;
    logic [AW-1:0]        o_io_addr;
    logic [15:0]          o_io_wdata;
    logic [NUM_IO*16-1:0] i_io_rdata;
    logic [NUM_IO-1:0]    i_io_rdy;
    dbus_state_t          dbg_state;
`ifdef DBUS_ERR_CAPTURE_EN
    logic [AW-1:0]        o_err_addr;
    logic                 o_err_valid;
`endif

    dbus_router #(
        .AW(AW), .MEM_AW(MEM_AW), .MEM_RD_LAT(MEM_RD_LAT),
        .NUM_IO(NUM_IO), .IO_SEL_LSB(IO_SEL_LSB), .IO_TMO(IO_TMO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_insn_ce(i_insn_ce), .i_addr(i_addr),
        .i_sw(i_sw), .i_sb(i_sb), .i_lw(i_lw), .i_lb(i_lb), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_rdy(o_rdy), .o_bus_err(o_bus_err),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
        .o_mem_we_h(o_mem_we_h), .o_mem_we_l(o_mem_we_l),
        .o_mem_din_h(o_mem_din_h), .o_mem_din_l(o_mem_din_l),
        .i_mem_dout_h(i_mem_dout_h), .i_mem_dout_l(i_mem_dout_l),
        .o_io_sel(o_io_sel), .o_io_we(o_io_we), .o_io_re(o_io_re),
        .o_io_addr(o_io_addr), .o_io_wdata(o_io_wdata),
        .i_io_rdata(i_io_rdata), .i_io_rdy(i_io_rdy),
        .o_dbg_state(dbg_state)
`ifdef DBUS_ERR_CAPTURE_EN
        , .o_err_addr(o_err_addr), .o_err_valid(o_err_valid)
`endif
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- BRAM with two-cycle read latency ----------------
    logic [15:0] bram [0:(1<<MEM_AW)-1];
    logic [15:0] bram_rd1;
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            bram_rd1 <= bram[o_mem_addr];
            {i_mem_dout_h, i_mem_dout_l} <= bram_rd1;
            if (o_mem_we_h) bram[o_mem_addr][15:8] <= o_mem_din_h;
            if (o_mem_we_l) bram[o_mem_addr][7:0]  <= o_mem_din_l;
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the age of the current access in cycles (0 = issue cycle) and
    // decides from the access rules when it completes and with what data.
    logic        t_acc, t_io, t_ld, t_st, t_lane;
    int          t_ch;
    int          t_word;
    assign t_acc  = i_sw | i_sb | i_lw | i_lb;
    assign t_io   = i_addr[AW-1];
    assign t_ld   = i_lw | i_lb;
    assign t_st   = i_sw | i_sb;
    assign t_lane = i_addr[1];
    assign t_ch   = int'(i_addr[IO_SEL_LSB +: 2]);
    assign t_word = int'(i_addr[MEM_AW:1]);

    logic [15:0] shadow [0:(1<<MEM_AW)-1];
    logic [15:0] exp_q[$];
    int          m_age  = 0;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    logic [15:0] m_data = 16'h0;

    function automatic logic [15:0] exp_mem_load();
        logic [15:0] w;
        w = shadow[t_word];
        if (i_lw) return w;
        return t_lane ? {8'h00, w[7:0]} : {8'h00, w[15:8]};
    endfunction

    always @(posedge i_clk) begin
        m_err = 1'b0;
        if (!i_rst && t_st && !t_io) begin
            if (i_sw)        shadow[t_word]       = i_wdata;
            else if (t_lane) shadow[t_word][7:0]  = i_wdata[7:0];
            else             shadow[t_word][15:8] = i_wdata[7:0];
        end
        if (i_rst || i_insn_ce || !t_acc) begin
            m_age  = 0;
            m_done = 1'b0;
        end else begin
            if (!m_done && t_ld && !t_io && m_age == MEM_RD_LAT) begin
                m_done = 1'b1;
                m_data = exp_mem_load();
                exp_q.push_back(m_data);
            end else if (!m_done && t_io && m_age >= 1) begin
                if (i_io_rdy[t_ch]) begin
                    m_done = 1'b1;
                    if (t_ld) begin
                        m_data = i_io_rdata[t_ch*16 +: 16];
                        exp_q.push_back(m_data);
                    end
                end else if (m_age - 1 == IO_TMO) begin
                    m_done = 1'b1;
                    m_err  = 1'b1;
                    m_data = 16'h0000;
                    if (t_ld) exp_q.push_back(m_data);
                end
            end
            m_age++;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit popped = 1'b0;
    always @(negedge i_clk) begin
        logic              in_wait;
        logic [NUM_IO-1:0] exp_sel;
        logic [15:0]       e;
        if (cmp_en && !i_rst) begin
            in_wait = t_acc && t_io && (m_age >= 1) && !m_done;
            exp_sel = in_wait ? (NUM_IO'(1) << t_ch) : '0;
            chk("rdy",     o_rdy,     !t_acc || (t_st && !t_io) || m_done);
            chk("bus_err", o_bus_err, m_err);
            chk("io_sel",  o_io_sel,  exp_sel);
            chk("io_re",   o_io_re,   in_wait && t_ld);
            chk("io_we",   o_io_we,   in_wait && t_st);
            chk("mem_en",  o_mem_en,  t_acc && !t_io);
            chk("we_h",    o_mem_we_h, !t_io && (i_sw || (i_sb && !t_lane)));
            chk("we_l",    o_mem_we_l, !t_io && (i_sw || (i_sb && t_lane)));
            chk("din_h",   o_mem_din_h, i_sw ? i_wdata[15:8] : i_wdata[7:0]);
            chk("din_l",   o_mem_din_l, i_wdata[7:0]);
            if (t_acc && !t_io) chk("mem_addr", o_mem_addr, t_word);
            if (in_wait) begin
                chk("io_addr",  o_io_addr,  i_addr);
                chk("io_wdata", o_io_wdata, i_wdata);
            end
            if (m_done && t_ld) begin
                if (!popped) begin
                    popped = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL rdata_q: got 0x%0h with no expected entry at %0t", o_rdata, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata_first", o_rdata, e);
                    end
                end else begin
                    chk("rdata_hold", o_rdata, m_data);
                end
            end
            if (!m_done) popped = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic end_access();
        tick();
        i_insn_ce = 1'b1;
        tick();
        i_insn_ce = 1'b0;
        i_sw = 1'b0; i_sb = 1'b0; i_lw = 1'b0; i_lb = 1'b0;
        i_io_rdy = '0;
    endtask

    // Issues one access, raises the channel ready rdy_dly wait cycles into
    // IO_WAIT (negative: never), and reports completion age and data.
    task automatic access(input logic [15:0] a, input logic sw, input logic sb,
                          input logic lw, input logic lb, input logic [15:0] wd,
                          input int rdy_dly, output logic [15:0] data,
                          output int rdy_age, output int err_cnt,
                          output logic [NUM_IO-1:0] sel1);
        bit got;
        int hold;
        i_addr = a; i_sw = sw; i_sb = sb; i_lw = lw; i_lb = lb; i_wdata = wd;
        rdy_age = -1; err_cnt = 0; data = 16'h0; sel1 = '0; got = 1'b0; hold = 0;
        for (int age = 0; age < 60; age++) begin
            i_io_rdy = (rdy_dly >= 0 && age == rdy_dly + 1) ?
                       (NUM_IO'(1) << a[IO_SEL_LSB +: 2]) : '0;
            @(negedge i_clk);
            if (o_bus_err) err_cnt++;
            if (age == 1) sel1 = o_io_sel;
            if (o_rdy && !got) begin
                got = 1'b1; rdy_age = age; data = o_rdata;
            end
            if (got) hold++;
            if (hold == 3) break;
            tick();
        end
        if (!got) begin
            n_chk++;
            $display("FAIL access_timeout: addr 0x%0h never saw o_rdy, required within 60 cycles", a);
        end
        end_access();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0]       d;
        int                ra;
        int                ec;
        logic [NUM_IO-1:0] s;

        i_rst = 1'b1; i_insn_ce = 1'b0; i_addr = '0; i_wdata = '0;
        i_sw = 1'b0; i_sb = 1'b0; i_lw = 1'b0; i_lb = 1'b0; i_io_rdy = '0;
        i_io_rdata = {16'h4444, 16'hBEEF, 16'h1111, 16'h0F0F};
        repeat (3) tick();
        i_rst  = 1'b0;
        cmp_en = 1'b1;
        @(negedge i_clk);
        chk("reset_rdy",   o_rdy, 1'b1);
        chk("reset_err",   o_bus_err, 1'b0);
        chk("reset_sel",   o_io_sel, 4'b0000);
        chk("reset_rdata", o_rdata, 16'h0000);
        chk("reset_state", dbg_state, ST_IDLE);
`ifdef DBUS_ERR_CAPTURE_EN
        chk("reset_err_valid", o_err_valid, 1'b0);
`endif
        tick();

        // word store then word load through the two-cycle BRAM
        access(16'h0010, 1, 0, 0, 0, 16'hA55A, -1, d, ra, ec, s);
        chk("sw_rdy_age", ra, 0);
        access(16'h0010, 0, 0, 1, 0, 16'h0000, -1, d, ra, ec, s);
        chk("lw_a55a", d, 16'hA55A);
        chk("lw_rdy_age", ra, 3);

        // byte store into lane 1 over 16'h1234
        access(16'h0010, 1, 0, 0, 0, 16'h1234, -1, d, ra, ec, s);
        access(16'h0012, 1, 0, 0, 0, 16'h1234, -1, d, ra, ec, s);
        i_addr = 16'h0012; i_sb = 1'b1; i_wdata = 16'h0077;
        @(negedge i_clk);
        chk("sb_we_l", o_mem_we_l, 1'b1);
        chk("sb_we_h", o_mem_we_h, 1'b0);
        chk("sb_din_l", o_mem_din_l, 8'h77);
        chk("sb_rdy", o_rdy, 1'b1);
        end_access();
        access(16'h0012, 0, 0, 1, 0, 16'h0000, -1, d, ra, ec, s);
        chk("lw_after_sb", d, 16'h1277);
        access(16'h0012, 0, 0, 0, 1, 16'h0000, -1, d, ra, ec, s);
        chk("lb_lane1", d, 16'h0077);
        access(16'h0010, 0, 0, 0, 1, 16'h0000, -1, d, ra, ec, s);
        chk("lb_lane0", d, 16'h0012);

        // IO read on channel 2, ready in the sixth wait cycle
        access(16'hA000, 0, 0, 1, 0, 16'h0000, 5, d, ra, ec, s);
        chk("io_rd_data", d, 16'hBEEF);
        chk("io_rd_sel", s, 4'b0100);
        chk("io_rd_age", ra, 7);
        chk("io_rd_err", ec, 0);

        // IO read on channel 1 that never answers
        access(16'h9000, 0, 0, 1, 0, 16'h0000, -1, d, ra, ec, s);
        chk("tmo_data", d, 16'h0000);
        chk("tmo_age", ra, 10);
        chk("tmo_err_pulses", ec, 1);
`ifdef DBUS_ERR_CAPTURE_EN
        chk("tmo_err_addr", o_err_addr, 16'h9000);
        chk("tmo_err_valid", o_err_valid, 1'b1);
`endif

        // ready arrives in the timeout cycle: ready wins
        access(16'hB000, 0, 0, 1, 0, 16'h0000, 8, d, ra, ec, s);
        chk("race_data", d, 16'h4444);
        chk("race_age", ra, 10);
        chk("race_err", ec, 0);

        // IO word write on channel 2
        access(16'hA002, 1, 0, 0, 0, 16'hCAFE, 0, d, ra, ec, s);
        chk("io_wr_age", ra, 2);
        chk("io_wr_sel", s, 4'b0100);
        chk("io_wr_err", ec, 0);

`ifdef DBUS_ERR_CAPTURE_EN
        // a second timeout replaces the recorded address
        access(16'hD000, 0, 0, 1, 0, 16'h0000, -1, d, ra, ec, s);
        chk("tmo2_err_addr", o_err_addr, 16'hD000);
        chk("tmo2_err_valid", o_err_valid, 1'b1);
`endif

        // reset while waiting on channel 3
        i_addr = 16'hB000; i_lw = 1'b1;
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_lw  = 1'b0;
        @(negedge i_clk);
        chk("rst_wait_sel", o_io_sel, 4'b0000);
        chk("rst_wait_re", o_io_re, 1'b0);
        chk("rst_wait_state", dbg_state, ST_IDLE);
        chk("rst_wait_err", o_bus_err, 1'b0);
`ifdef DBUS_ERR_CAPTURE_EN
        chk("rst_err_valid", o_err_valid, 1'b0);
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
